// File: rtl/oam_dma_if.sv
// Shared CPU/memory bus bundle for the sprite DMA engine; master = DMA side.
interface oam_dma_if;
  logic        cpu_cs;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy;
  logic        dma_active;
  logic        mem_cs;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_doe;

  modport master (
    input  cpu_cs, cpu_wr, cpu_addr, cpu_dout, mem_din,
    output cpu_rdy, dma_active, mem_cs, mem_rd, mem_wr, mem_addr, mem_dout, mem_doe
  );

  modport slave (
    output cpu_cs, cpu_wr, cpu_addr, cpu_dout, mem_din,
    input  cpu_rdy, dma_active, mem_cs, mem_rd, mem_wr, mem_addr, mem_dout, mem_doe
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a $4014 write stalls the CPU and copies page {XX,00..FF} to $2004; OAM_DMA_ALIGN_EN adds the odd-parity ALIGN cycle.
// All bus outputs are registered from next state; busy = 1 + align + 256*(2+READ_LATENCY) cycles with cpu_rdy low.
module oam_dma #(
  parameter int READ_LATENCY = 1
) (
  input logic       i_clk,
  input logic       i_rst_n,
  oam_dma_if.master bus
);

  localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
    S_ALIGN = 3'd2,
`endif
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t        r_state;
  logic [7:0]    r_page;
  logic [7:0]    r_idx;
  logic [CW-1:0] r_rcnt;
`ifdef OAM_DMA_ALIGN_EN
  logic          r_par;
`endif

  logic          r_cpu_rdy;
  logic          r_dma_active;
  logic          r_mem_cs;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [15:0]   r_mem_addr;
  logic [7:0]    r_mem_dout;
  logic          r_mem_doe;

  state_t        w_state_nxt;
  logic [7:0]    w_page_nxt;
  logic [7:0]    w_idx_nxt;
  logic [CW-1:0] w_rcnt_nxt;
  logic          w_trig;

  logic          w_cpu_rdy;
  logic          w_mem_cs;
  logic          w_mem_rd;
  logic          w_mem_wr;
  logic [15:0]   w_mem_addr;
  logic [7:0]    w_mem_dout;
  logic          w_mem_doe;

  assign w_trig = !bus.cpu_cs && bus.cpu_wr && (bus.cpu_addr == 16'h4014);

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_rcnt_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_page_nxt  = bus.cpu_dout;
          w_idx_nxt   = 8'h00;
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        w_state_nxt = r_par ? S_ALIGN : S_READ;
`else
        w_state_nxt = S_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: w_state_nxt = S_READ;
`endif
      S_READ: begin
        if (r_rcnt == RD_LAST) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end
      S_WRITE: begin
        // idx wraps inside the page; the carry is deliberately dropped
        w_idx_nxt   = r_idx + 8'd1;
        w_state_nxt = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus lines up with the state register.
  always_comb begin
    w_cpu_rdy  = (w_state_nxt == S_IDLE);
    w_mem_cs   = 1'b1;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_mem_addr = 16'h0000;
    w_mem_dout = 8'h00;
    w_mem_doe  = 1'b0;
    case (w_state_nxt)
      S_READ: begin
        w_mem_cs   = 1'b0;
        w_mem_rd   = 1'b1;
        w_mem_addr = {w_page_nxt, w_idx_nxt};
      end
      S_WRITE: begin
        // WRITE is only entered from the final READ edge, so mem_din is the fetched byte
        w_mem_cs   = 1'b0;
        w_mem_wr   = 1'b1;
        w_mem_doe  = 1'b1;
        w_mem_addr = 16'h2004;
        w_mem_dout = bus.mem_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_page       <= 8'h00;
      r_idx        <= 8'h00;
      r_rcnt       <= '0;
`ifdef OAM_DMA_ALIGN_EN
      r_par        <= 1'b0;
`endif
      r_cpu_rdy    <= 1'b1;
      r_dma_active <= 1'b0;
      r_mem_cs     <= 1'b1;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_mem_dout   <= 8'h00;
      r_mem_doe    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_page       <= w_page_nxt;
      r_idx        <= w_idx_nxt;
      r_rcnt       <= w_rcnt_nxt;
`ifdef OAM_DMA_ALIGN_EN
      r_par        <= ~r_par;
`endif
      r_cpu_rdy    <= w_cpu_rdy;
      r_dma_active <= !w_cpu_rdy;
      r_mem_cs     <= w_mem_cs;
      r_mem_rd     <= w_mem_rd;
      r_mem_wr     <= w_mem_wr;
      r_mem_addr   <= w_mem_addr;
      r_mem_dout   <= w_mem_dout;
      r_mem_doe    <= w_mem_doe;
    end
  end

  assign bus.cpu_rdy    = r_cpu_rdy;
  assign bus.dma_active = r_dma_active;
  assign bus.mem_cs     = r_mem_cs;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_dout   = r_mem_dout;
  assign bus.mem_doe    = r_mem_doe;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: READ_LATENCY=1 and =2 instances against byte[a]=a[7:0]^5A memory models.
module tb_oam_dma;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst2_n;
  oam_dma_if b1();
  oam_dma_if b2();

  oam_dma #(.READ_LATENCY(1)) u_dut1 (.i_clk(clk), .i_rst_n(rst1_n), .bus(b1.master));
  oam_dma #(.READ_LATENCY(2)) u_dut2 (.i_clk(clk), .i_rst_n(rst2_n), .bus(b2.master));

`ifdef OAM_DMA_ALIGN_EN
  localparam int A_EN = 1;
`else
  localparam int A_EN = 0;
`endif
  localparam logic [31:0] RST_OUTS = {2'b00, 1'b1, 1'b0, 1'b1, 3'b000, 16'h0000, 8'h00};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // memory models: 1-cycle and 2-cycle read latency
  logic [7:0] m2_s1;
  always @(posedge clk) begin
    b1.mem_din <= mem_f(b1.mem_addr[7:0]);
    m2_s1      <= mem_f(b2.mem_addr[7:0]);
    b2.mem_din <= m2_s1;
  end

  logic par_m [2];
  always @(posedge clk) begin
    par_m[0] <= rst1_n ? ~par_m[0] : 1'b0;
    par_m[1] <= rst2_n ? ~par_m[1] : 1'b0;
  end

  int          cyc [2]       = '{0, 0};
  int          busy [2]      = '{0, 0};
  int          viol [2]      = '{0, 0};
  logic        prev_rd [2]   = '{1'b0, 1'b0};
  logic        prev_act [2]  = '{1'b0, 1'b0};
  logic [15:0] prev_addr [2] = '{16'h0, 16'h0};
  logic        halt_par [2]  = '{1'b0, 1'b0};
  logic [15:0] rdq0[$], rdq1[$];
  int          rcq0[$], rcq1[$];
  logic [7:0]  wrq0[$], wrq1[$];

  task automatic mon(input int d, input logic rdy, act, cs, rd, wr, doe,
                     input logic [15:0] addr, input logic [7:0] dout, input logic par);
    cyc[d]++;
    if (!rdy) busy[d]++;
    if (rdy == act) viol[d]++;
    if ((rd && wr) || (doe && !wr) || ((rd || wr) && cs) || (wr && addr != 16'h2004)) viol[d]++;
    if (rd && prev_rd[d] && addr != prev_addr[d]) viol[d]++;
    if (rd && !prev_rd[d]) begin
      if (d == 0) begin rdq0.push_back(addr); rcq0.push_back(cyc[d]); end
      else        begin rdq1.push_back(addr); rcq1.push_back(cyc[d]); end
    end
    if (wr) begin
      if (d == 0) wrq0.push_back(dout);
      else        wrq1.push_back(dout);
    end
    if (act && !prev_act[d]) halt_par[d] = par;
    prev_rd[d]   = rd;
    prev_addr[d] = addr;
    prev_act[d]  = act;
  endtask

  always @(negedge clk) begin
    mon(0, b1.cpu_rdy, b1.dma_active, b1.mem_cs, b1.mem_rd, b1.mem_wr, b1.mem_doe,
        b1.mem_addr, b1.mem_dout, par_m[0]);
    mon(1, b2.cpu_rdy, b2.dma_active, b2.mem_cs, b2.mem_rd, b2.mem_wr, b2.mem_doe,
        b2.mem_addr, b2.mem_dout, par_m[1]);
  end

  function automatic logic rdy(input int d);
    return (d == 0) ? b1.cpu_rdy : b2.cpu_rdy;
  endfunction

  function automatic logic [31:0] outs(input int d);
    if (d == 0)
      return {2'b00, b1.cpu_rdy, b1.dma_active, b1.mem_cs, b1.mem_rd, b1.mem_wr, b1.mem_doe,
              b1.mem_addr, b1.mem_dout};
    return {2'b00, b2.cpu_rdy, b2.dma_active, b2.mem_cs, b2.mem_rd, b2.mem_wr, b2.mem_doe,
            b2.mem_addr, b2.mem_dout};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cpu_bus(input int d, input logic cs, wr, input logic [15:0] addr, input logic [7:0] dat);
    if (d == 0) begin
      b1.cpu_cs = cs; b1.cpu_wr = wr; b1.cpu_addr = addr; b1.cpu_dout = dat;
    end else begin
      b2.cpu_cs = cs; b2.cpu_wr = wr; b2.cpu_addr = addr; b2.cpu_dout = dat;
    end
  endtask

  // want = required parity in the HALT cycle, or -1 to trigger immediately
  task automatic trigger(input int d, input logic [7:0] page, input int want, output int tc);
    if (want >= 0 && par_m[d] == want[0]) tick(1);
    tc = cyc[d];
    cpu_bus(d, 1'b0, 1'b1, 16'h4014, page);
    tick(1);
    cpu_bus(d, 1'b1, 1'b0, 16'h0000, 8'h00);
    chk("rdy_low_T1", 32'(rdy(d)), 32'd0);
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (!rdy(d) && n < budget) begin tick(1); n++; end
    chk("done_in_budget", 32'(rdy(d)), 32'd1);
  endtask

  task automatic snap(input int d, output int rb, output int wb, output int bb, output int vb);
    rb = (d == 0) ? rdq0.size() : rdq1.size();
    wb = (d == 0) ? wrq0.size() : wrq1.size();
    bb = busy[d];
    vb = viol[d];
  endtask

  task automatic verify(input int d, input logic [7:0] page, input int rb, wb, bb, vb, tc, rl);
    int hp = A_EN * int'(halt_par[d]);
    int nr = ((d == 0) ? rdq0.size() : rdq1.size()) - rb;
    int nw = ((d == 0) ? wrq0.size() : wrq1.size()) - wb;
    chk("busy_cycles", 32'(busy[d] - bb), 32'(1 + hp + 256 * (2 + rl)));
    chk("n_reads", 32'(nr), 32'd256);
    chk("n_writes", 32'(nw), 32'd256);
    chk("bus_violations", 32'(viol[d] - vb), 32'd0);
    if (nr > 0)
      chk("first_rd_cycle", 32'(((d == 0) ? rcq0[rb] : rcq1[rb]) - tc), 32'(3 + hp));
    for (int k = 0; k < 256 && k < nr; k++)
      chk("rd_addr", 32'((d == 0) ? rdq0[rb + k] : rdq1[rb + k]), {16'h0, page, 8'(k)});
    for (int k = 0; k < 256 && k < nw; k++)
      chk("wr_data", 32'((d == 0) ? wrq0[wb + k] : wrq1[wb + k]), 32'(8'(k) ^ 8'h5A));
  endtask

  initial begin
    int rb, wb, bb, vb, tc, n;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    cpu_bus(0, 1'b1, 1'b0, 16'h0000, 8'h00);
    cpu_bus(1, 1'b1, 1'b0, 16'h0000, 8'h00);
    tick(3);
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    chk("reset_outs_d1", outs(0), RST_OUTS);
    chk("reset_outs_d2", outs(1), RST_OUTS);

    // non-triggering accesses
    snap(0, rb, wb, bb, vb);
    cpu_bus(0, 1'b0, 1'b1, 16'h4013, 8'h02); tick(1);
    cpu_bus(0, 1'b0, 1'b1, 16'h4015, 8'h02); tick(1);
    cpu_bus(0, 1'b0, 1'b0, 16'h4014, 8'h02); tick(1);
    cpu_bus(0, 1'b1, 1'b1, 16'h4014, 8'h02); tick(1);
    cpu_bus(0, 1'b1, 1'b0, 16'h0000, 8'h00); tick(3);
    chk("no_trig_busy", 32'(busy[0] - bb), 32'd0);
    chk("no_trig_reads", 32'(rdq0.size() - rb), 32'd0);
    chk("no_trig_outs", outs(0), RST_OUTS);

    // page 02, HALT at even parity, with a stray $4014 write while busy
    snap(0, rb, wb, bb, vb);
    trigger(0, 8'h02, 0, tc);
    tick(50);
    cpu_bus(0, 1'b0, 1'b1, 16'h4014, 8'h77); tick(1);
    cpu_bus(0, 1'b1, 1'b0, 16'h0000, 8'h00);
    wait_idle(0, 1000);
    verify(0, 8'h02, rb, wb, bb, vb, tc, 1);

    // page 02, HALT at odd parity
    tick(2);
    snap(0, rb, wb, bb, vb);
    trigger(0, 8'h02, 1, tc);
    wait_idle(0, 1000);
    chk("odd_halt_par", 32'(halt_par[0]), 32'd1);
    verify(0, 8'h02, rb, wb, bb, vb, tc, 1);

    // page FF: last read FFFF, then retrigger in the first idle cycle
    tick(2);
    snap(0, rb, wb, bb, vb);
    trigger(0, 8'hFF, -1, tc);
    wait_idle(0, 1000);
    verify(0, 8'hFF, rb, wb, bb, vb, tc, 1);
    chk("ff_last_rd", 32'(rdq0[rdq0.size() - 1]), 32'h0000_FFFF);
    chk("ff_idle_act", 32'(b1.dma_active), 32'd0);

    snap(0, rb, wb, bb, vb);
    trigger(0, 8'h01, -1, tc);
    n = 0;
    while (!(b1.mem_rd && b1.mem_addr == 16'h0164) && n < 1000) begin tick(1); n++; end
    chk("found_rd100", 32'(b1.mem_addr), 32'h0000_0164);
    rst1_n = 1'b0;
    tick(1);
    chk("midrst_outs", outs(0), RST_OUTS);
    chk("midrst_wr_count", 32'(wrq0.size() - wb), 32'd100);
    tick(1);
    rst1_n = 1'b1;
    tick(3);
    chk("midrst_no_wr", 32'(wrq0.size() - wb), 32'd100);
    chk("midrst_idle_outs", outs(0), RST_OUTS);

    snap(0, rb, wb, bb, vb);
    trigger(0, 8'h03, -1, tc);
    wait_idle(0, 1000);
    chk("retrig_first_rd", 32'(rdq0[rb]), 32'h0000_0300);
    verify(0, 8'h03, rb, wb, bb, vb, tc, 1);

    // 2-cycle-latency memory
    snap(1, rb, wb, bb, vb);
    trigger(1, 8'h05, 0, tc);
    wait_idle(1, 1300);
    verify(1, 8'h05, rb, wb, bb, vb, tc, 2);
    tick(2);
    chk("rl2_idle_outs", outs(1), RST_OUTS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
